// File: rtl/mem_stage_hs_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_hs_if #(
    parameter int XLEN = 32
);
    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN-1:0]     dmem_addr;
    logic [XLEN-1:0]     dmem_wdata;
    logic [XLEN/8-1:0]   dmem_be;
    logic                dmem_ready;
    logic [XLEN-1:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM stage with MEM/WB register: variable-latency data-memory handshake, upstream stall,
// bus timeout, sub-word byte lanes with load extension, and misalignment flagging.
module mem_stage_hs #(
    parameter int XLEN        = 32,
    parameter int RDW_W       = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [RDW_W-1:0]  RDM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    mem_stage_hs_if.master    dmem,
    output logic              StallM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [RDW_W-1:0]  RDW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic              MisalignW,
    output logic              TimeoutW
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic              capWe, capLoad, capRegWrite, capResultSrc;
    logic [2:0]        capF3;
    logic [RDW_W-1:0]  capRd;
    logic [XLEN-1:0]   capAlu, capWdata;
    logic [NB-1:0]     capBe;

    // Illegal size encodings are folded into the misalignment flag.
    function automatic logic badOp(input logic [2:0] f, input logic [OFFW-1:0] off);
        logic [2:0] o;
        logic       illegal, mis;
        o = '0;
        o[OFFW-1:0] = off;
        illegal = (f == 3'b111) || (XLEN == 32 && (f == 3'b011 || f == 3'b110));
        case (f[1:0])
            2'b01:   mis = o[0];
            2'b10:   mis = |o[1:0];
            2'b11:   mis = |o;
            default: mis = 1'b0;
        endcase
        return illegal | mis;
    endfunction

    function automatic logic [NB-1:0] sizeMask(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return NB'(1);
            2'b01:   return NB'(3);
            2'b10:   return NB'(15);
            default: return NB'(8'hFF);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] loadExt(input logic [2:0] f, input logic [XLEN-1:0] rdata,
                                                input logic [OFFW-1:0] off);
        logic [XLEN-1:0] sh, keep;
        logic            sb;
        sh = rdata >> {off, 3'b000};
        case (f[1:0])
            2'b00:   begin sb = sh[7];      keep = XLEN'(8'hFF);         end
            2'b01:   begin sb = sh[15];     keep = XLEN'(16'hFFFF);      end
            2'b10:   begin sb = sh[31];     keep = XLEN'(32'hFFFF_FFFF); end
            default: begin sb = sh[XLEN-1]; keep = '1;                   end
        endcase
        return (sh & keep) | ((sb & ~f[2]) ? ~keep : '0);
    endfunction

    logic              memOp, misM, isLoadM, timeoutNow;
    logic [OFFW-1:0]   offM;
    logic [NB-1:0]     stBe;
    logic [XLEN-1:0]   stWdata;

    assign memOp   = ValidM & (MemReadM | MemWriteM);
    assign isLoadM = MemReadM & ~MemWriteM;
    assign offM    = ALUResultM[OFFW-1:0];
    assign misM    = badOp(Funct3M, offM);
    assign stBe    = sizeMask(Funct3M) << offM;
    assign stWdata = WriteDataM << {offM, 3'b000};
    assign timeoutNow = (state == S_WAIT) && !dmem.dmem_ready && (cnt == CNTW'(TIMEOUT_CYC));

    logic              nValid, nRegWrite, nResultSrc, nMis, nTo;
    logic [RDW_W-1:0]  nRd;
    logic [XLEN-1:0]   nAlu, nRead;

    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        dmem.dmem_be    = '0;
        StallM          = 1'b0;
        nValid = 1'b0; nRegWrite = 1'b0; nResultSrc = 1'b0; nMis = 1'b0; nTo = 1'b0;
        nRd = '0; nAlu = '0; nRead = '0;
        case (state)
            S_IDLE: begin
                if (memOp && !misM) begin
                    dmem.dmem_req   = 1'b1;
                    dmem.dmem_we    = MemWriteM;
                    dmem.dmem_addr  = {ALUResultM[XLEN-1:OFFW], {OFFW{1'b0}}};
                    dmem.dmem_wdata = stWdata;
                    dmem.dmem_be    = stBe;
                    StallM          = ~dmem.dmem_ready;
                end
                if (memOp && misM) begin
                    nValid = 1'b1; nMis = 1'b1; nRd = RDM; nAlu = ALUResultM;
                end else if (!(memOp && !dmem.dmem_ready)) begin
                    nValid     = ValidM;
                    nRegWrite  = ValidM & RegWriteM;
                    nResultSrc = ValidM & ResultSrcM;
                    nRd        = RDM;
                    nAlu       = ALUResultM;
                    nRead      = (memOp && isLoadM) ? loadExt(Funct3M, dmem.dmem_rdata, offM) : '0;
                end
            end
            S_WAIT: begin
                if (!timeoutNow) begin
                    dmem.dmem_req   = 1'b1;
                    dmem.dmem_we    = capWe;
                    dmem.dmem_addr  = {capAlu[XLEN-1:OFFW], {OFFW{1'b0}}};
                    dmem.dmem_wdata = capWdata;
                    dmem.dmem_be    = capBe;
                    StallM          = ~dmem.dmem_ready;
                end
                if (dmem.dmem_ready) begin
                    nValid = 1'b1; nRegWrite = capRegWrite; nResultSrc = capResultSrc;
                    nRd = capRd; nAlu = capAlu;
                    nRead = capLoad ? loadExt(capF3, dmem.dmem_rdata, capAlu[OFFW-1:0]) : '0;
                end else if (timeoutNow) begin
                    nValid = 1'b1; nTo = 1'b1; nRd = capRd; nAlu = capAlu;
                end
            end
            default: ;
        endcase
        // Reset must silence the bus even while the M inputs present an aligned op.
        if (rst) begin
            dmem.dmem_req = 1'b0;
            StallM        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            capWe <= 1'b0; capLoad <= 1'b0; capRegWrite <= 1'b0; capResultSrc <= 1'b0;
            capF3 <= '0; capRd <= '0; capAlu <= '0; capWdata <= '0; capBe <= '0;
            ValidW <= 1'b0; RegWriteW <= 1'b0; ResultSrcW <= 1'b0; RDW <= '0;
            ALUResultW <= '0; ReadDataW <= '0; MisalignW <= 1'b0; TimeoutW <= 1'b0;
        end else begin
            ValidW     <= nValid;
            RegWriteW  <= nRegWrite;
            ResultSrcW <= nResultSrc;
            RDW        <= nRd;
            ALUResultW <= nAlu;
            ReadDataW  <= nRead;
            MisalignW  <= nMis;
            TimeoutW   <= nTo;
            case (state)
                S_IDLE: begin
                    if (memOp && !misM && !dmem.dmem_ready) begin
                        state        <= S_WAIT;
                        cnt          <= CNTW'(1);
                        capWe        <= MemWriteM;
                        capLoad      <= isLoadM;
                        capRegWrite  <= RegWriteM;
                        capResultSrc <= ResultSrcM;
                        capF3        <= Funct3M;
                        capRd        <= RDM;
                        capAlu       <= ALUResultM;
                        capWdata     <= stWdata;
                        capBe        <= stBe;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ready || timeoutNow) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: per-cycle comparison against a transaction-level model
// plus hand-computed literal expectations for the key load/store/exception scenarios.
module tb_mem_stage_hs;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, ResultSrcM, MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [4:0]  RDM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, ValidW, RegWriteW, ResultSrcW, MisalignW, TimeoutW;
    logic [4:0]  RDW;
    logic [31:0] ALUResultW, ReadDataW;

    mem_stage_hs_if #(.XLEN(32)) bus ();

    mem_stage_hs #(.XLEN(32), .RDW_W(5), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RDM(RDM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dmem(bus),
        .StallM(StallM), .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RDW(RDW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .MisalignW(MisalignW), .TimeoutW(TimeoutW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        v, rw, rs, mis, to;
        logic [4:0]  rd;
        logic [31:0] alu, rdd;
        logic        full;
    } wexp_t;

    wexp_t       expW, pendW;
    logic        checkEn = 1'b0;
    logic        expReq, expStall, expWe;
    logic [31:0] expAddr, expWdata;
    logic [3:0]  expBe;
    logic        obsReq, obsWe;
    logic [3:0]  obsBe;
    logic [31:0] obsWdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the architectural rules.
    function automatic int unsigned sizeBytes(input logic [2:0] f);
        return 32'd1 << f[1:0];
    endfunction

    function automatic logic modelMis(input logic [2:0] f, input logic [31:0] a);
        logic legal;
        legal = !(f == 3'd3 || f == 3'd6 || f == 3'd7);
        return !legal || ((a % sizeBytes(f)) != 0);
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f, input logic [31:0] a);
        logic [7:0] m;
        m = ((8'd1 << sizeBytes(f)) - 8'd1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] modelWd(input logic [31:0] wd, input logic [31:0] a);
        logic [63:0] t;
        t = {32'd0, wd} << (8 * (a % 4));
        return t[31:0];
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rdat);
        int unsigned sz;
        logic [31:0] b, mask, v;
        sz   = sizeBytes(f);
        b    = rdat >> (8 * (a % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = b & mask;
        if (!f[2] && (((v >> (8 * sz - 1)) & 32'd1) != 0)) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            chk("StallM", 64'(StallM), 64'(expStall));
            chk("dmem_req", 64'(bus.dmem_req), 64'(expReq));
            if (expReq) begin
                chk("dmem_we", 64'(bus.dmem_we), 64'(expWe));
                chk("dmem_addr", 64'(bus.dmem_addr), 64'(expAddr));
                chk("dmem_be", 64'(bus.dmem_be), 64'(expBe));
                chk("dmem_wdata", 64'(bus.dmem_wdata), 64'(expWdata));
            end
            chk("ValidW", 64'(ValidW), 64'(expW.v));
            chk("RegWriteW", 64'(RegWriteW), 64'(expW.rw));
            chk("MisalignW", 64'(MisalignW), 64'(expW.mis));
            chk("TimeoutW", 64'(TimeoutW), 64'(expW.to));
            if (expW.full) begin
                chk("ResultSrcW", 64'(ResultSrcW), 64'(expW.rs));
                chk("RDW", 64'(RDW), 64'(expW.rd));
                chk("ALUResultW", 64'(ALUResultW), 64'(expW.alu));
                chk("ReadDataW", 64'(ReadDataW), 64'(expW.rdd));
            end
        end
    end

    task automatic clearInputs();
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        Funct3M = 3'd0; RDM = 5'd0; ALUResultM = 32'd0; WriteDataM = 32'd0;
    endtask

    function automatic wexp_t bubble();
        wexp_t w;
        w = '0;
        w.full = 1'b1;
        return w;
    endfunction

    // Drives one instruction, holding it while stalled; lat = ready-low cycles before ready.
    task automatic doOp(input logic rdq, input logic wrq, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int lat,
                        input logic [4:0] rd, input logic rw, input logic rs, output int stallCnt);
        logic  mem, mis, ld, fin;
        wexp_t res, exc;
        mem = rdq | wrq;
        mis = mem && modelMis(f, a);
        ld  = rdq && !wrq;
        ValidM = 1'b1; RegWriteM = rw; ResultSrcM = rs; MemReadM = rdq; MemWriteM = wrq;
        Funct3M = f; RDM = rd; ALUResultM = a; WriteDataM = wd; bus.dmem_rdata = rdat;
        res = '0;
        res.v = 1'b1; res.rw = rw; res.rs = rs; res.rd = rd; res.alu = a;
        res.rdd = ld ? modelLoad(f, a, rdat) : 32'd0;
        res.full = 1'b1;
        stallCnt = 0;
        for (int c = 0; c <= TMO; c++) begin
            fin = 1'b0;
            expWe = wrq; expAddr = a & 32'hFFFF_FFFC; expBe = modelBe(f, a); expWdata = modelWd(wd, a);
            bus.dmem_ready = mem && !mis && (c == lat);
            exc = '0;
            exc.v = 1'b1;
            if (!mem) begin
                expReq = 1'b0; expStall = 1'b0; pendW = res; fin = 1'b1;
            end else if (mis) begin
                exc.mis = 1'b1;
                expReq = 1'b0; expStall = 1'b0; pendW = exc; fin = 1'b1;
            end else if (c == lat) begin
                expReq = 1'b1; expStall = 1'b0; pendW = res; fin = 1'b1;
            end else if (c == TMO) begin
                exc.to = 1'b1;
                expReq = 1'b0; expStall = 1'b0; pendW = exc; fin = 1'b1;
            end else begin
                expReq = 1'b1; expStall = 1'b1; pendW = bubble();
            end
            @(negedge clk);
            if (StallM) stallCnt++;
            if (c == 0) begin
                obsReq = bus.dmem_req; obsWe = bus.dmem_we; obsBe = bus.dmem_be; obsWdata = bus.dmem_wdata;
            end
            @(posedge clk);
            #1;
            expW = pendW;
            if (fin) break;
        end
        bus.dmem_ready = 1'b0;
        clearInputs();
    endtask

    task automatic idle(input int n);
        clearInputs();
        for (int i = 0; i < n; i++) begin
            expReq = 1'b0; expStall = 1'b0;
            @(posedge clk);
            #1;
            expW = bubble();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1;
        clearInputs();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'd0;
        expW = bubble(); pendW = bubble(); expReq = 1'b0; expStall = 1'b0; expWe = 1'b0;
        expAddr = '0; expWdata = '0; expBe = '0;
        ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100;
        #3;
        chk("rst_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_stall", 64'(StallM), 64'd0);
        chk("rst_validw", 64'(ValidW), 64'd0);
        chk("rst_alur", 64'(ALUResultW), 64'd0);
        chk("rst_rdata", 64'(ReadDataW), 64'd0);
        @(posedge clk);
        #1;
        clearInputs();
        rst = 1'b0;
        checkEn = 1'b1;

        // SW 0xDEADBEEF to 0x104, zero-wait
        doOp(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'd0, 0, 5'd0, 1'b0, 1'b0, s);
        chk("sw_req", 64'(obsReq), 64'd1);
        chk("sw_we", 64'(obsWe), 64'd1);
        chk("sw_be", 64'(obsBe), 64'hF);
        chk("sw_wdata", 64'(obsWdata), 64'hDEADBEEF);
        chk("sw_stall", 64'(s), 64'd0);

        // LB from 0x103, three wait cycles
        doOp(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h8012_3456, 3, 5'd5, 1'b1, 1'b1, s);
        chk("lb_stall", 64'(s), 64'd3);
        chk("lb_data", 64'(ReadDataW), 64'hFFFF_FF80);
        chk("lb_rd", 64'(RDW), 64'd5);

        // LHU from 0x102
        doOp(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'hBEEF_0000, 1, 5'd6, 1'b1, 1'b1, s);
        chk("lhu_data", 64'(ReadDataW), 64'h0000_BEEF);

        // SB 0xAB to 0x101
        doOp(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'd0, 2, 5'd0, 1'b0, 1'b0, s);
        chk("sb_be", 64'(obsBe), 64'b0010);
        chk("sb_wdata", 64'(obsWdata), 64'h0000_AB00);
        chk("sb_stall", 64'(s), 64'd2);

        // LW from 0x102: misaligned
        doOp(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 5'd9, 1'b1, 1'b1, s);
        chk("lwmis_req", 64'(obsReq), 64'd0);
        chk("lwmis_flag", 64'(MisalignW), 64'd1);
        chk("lwmis_regw", 64'(RegWriteW), 64'd0);

        // Load with ready never asserted
        doOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 1000, 5'd3, 1'b1, 1'b1, s);
        chk("to_stall", 64'(s), 64'd16);
        chk("to_flag", 64'(TimeoutW), 64'd1);
        chk("to_regw", 64'(RegWriteW), 64'd0);
        idle(1);

        doOp(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'h1234_5678, 0, 5'd4, 1'b1, 1'b1, s);
        chk("lw_after_to", 64'(ReadDataW), 64'h1234_5678);
        doOp(1'b1, 1'b0, 3'b001, 32'h106, 32'd0, 32'h8001_0000, 1, 5'd8, 1'b1, 1'b1, s);
        chk("lh_data", 64'(ReadDataW), 64'hFFFF_8001);
        doOp(1'b1, 1'b0, 3'b100, 32'h100, 32'd0, 32'h0000_00F0, 0, 5'd10, 1'b1, 1'b1, s);
        chk("lbu_data", 64'(ReadDataW), 64'h0000_00F0);
        doOp(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'd0, 0, 5'd0, 1'b0, 1'b0, s);
        chk("sh_be", 64'(obsBe), 64'b1100);
        chk("sh_wdata", 64'(obsWdata), 64'h1234_0000);
        doOp(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_1234, 32'd0, 0, 5'd0, 1'b0, 1'b0, s);
        doOp(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 5'd11, 1'b1, 1'b1, s);
        chk("ld_illegal", 64'(MisalignW), 64'd1);
        doOp(1'b1, 1'b0, 3'b110, 32'h100, 32'd0, 32'd0, 0, 5'd12, 1'b1, 1'b1, s);
        doOp(1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 32'd0, 32'd0, 0, 5'd7, 1'b1, 1'b0, s);
        chk("alu_pass", 64'(ALUResultW), 64'h0000_CAFE);
        doOp(1'b1, 1'b1, 3'b010, 32'h10C, 32'h0000_0055, 32'hFFFF_FFFF, 1, 5'd0, 1'b0, 1'b0, s);
        chk("rdwr_data", 64'(ReadDataW), 64'd0);
        // ready arrives on the same cycle the timeout would fire
        doOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h0BAD_F00D, TMO, 5'd13, 1'b1, 1'b1, s);
        chk("edge_stall", 64'(s), 64'd16);
        chk("edge_to", 64'(TimeoutW), 64'd0);
        chk("edge_data", 64'(ReadDataW), 64'h0BAD_F00D);

        // Reset pulse while an access is waiting
        checkEn = 1'b0;
        clearInputs();
        ValidM = 1'b1; MemReadM = 1'b1; RegWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100; RDM = 5'd2;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rstw_pre_req", 64'(bus.dmem_req), 64'd1);
        chk("rstw_pre_stall", 64'(StallM), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_req", 64'(bus.dmem_req), 64'd0);
        chk("rstw_stall", 64'(StallM), 64'd0);
        chk("rstw_validw", 64'(ValidW), 64'd0);
        chk("rstw_rdw", 64'(RDW), 64'd0);
        clearInputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expW = bubble(); expReq = 1'b0; expStall = 1'b0;
        checkEn = 1'b1;
        doOp(1'b1, 1'b0, 3'b010, 32'h110, 32'd0, 32'hA5A5_A5A5, 0, 5'd14, 1'b1, 1'b1, s);
        chk("post_rst_data", 64'(ReadDataW), 64'hA5A5_A5A5);
        idle(2);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
